// File: rtl/booth_mul_param.sv
// Sequential radix-4 Booth multiplier for signed or unsigned operands.
// One Booth digit is retired per CALC cycle. The product is only written to
// the result port when the operation completes, so partial sums never leak out.
module booth_mul_param #(
  parameter int WIDTH = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               op_start,
  input  logic               op_clear,
  input  logic               op_signed,
  input  logic [WIDTH-1:0]   multiplier,
  input  logic [WIDTH-1:0]   multiplicand,
  output logic               op_busy,
  output logic               op_done,
  output logic [2*WIDTH-1:0] result
);

  // Number of radix-4 digits once the multiplier is widened by two bits
  localparam int N  = WIDTH / 2 + 1;
  // Accumulator is wide enough that +/-2A at the top digit position never wraps
  localparam int AW = 2 * WIDTH + 4;
  // Latched multiplier: two extension bits, the operand, and the implicit zero
  localparam int BW = WIDTH + 3;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [AW-1:0]   a_q;
  logic [BW-1:0]   b_q;
  logic [AW-1:0]   acc_q;
  logic [AW-1:0]   acc_next;
  logic [AW-1:0]   pp;
  logic            pp_neg;
  logic [CW-1:0]   count_q;
  logic            load;
  logic            b_ext;

  // A new operation is accepted from IDLE or DONE; op_clear always wins
  assign load  = (state != CALC) && op_start && !op_clear;
  assign b_ext = op_signed & multiplier[WIDTH-1];

  assign op_busy = (state == CALC);
  assign op_done = (state == DONE);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: clear aborts or acknowledges, start is ignored while calculating
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (load) state_next = CALC;
      end
      CALC: begin
        if (op_clear)             state_next = IDLE;
        else if (count_q == LAST) state_next = DONE;
      end
      DONE: begin
        if (op_clear)  state_next = IDLE;
        else if (load) state_next = CALC;
      end
      default: state_next = IDLE;
    endcase
  end

  // Booth digit decode of the current low triplet into a partial product.
  // Subtraction is formed as one's complement plus a carry-in of one.
  always_comb begin
    pp     = '0;
    pp_neg = 1'b0;
    case (b_q[2:0])
      3'b001, 3'b010: pp = a_q;
      3'b011:         pp = a_q << 1;
      3'b100: begin
        pp     = a_q << 1;
        pp_neg = 1'b1;
      end
      3'b101, 3'b110: begin
        pp     = a_q;
        pp_neg = 1'b1;
      end
      default: pp = '0;
    endcase
    acc_next = acc_q + (pp_neg ? ~pp : pp) + {{(AW-1){1'b0}}, pp_neg};
  end

  // Datapath: the multiplicand is pre-extended on latch (which captures the mode)
  // and shifted left two places per digit; the multiplier is shifted right so the
  // active triplet is always in the low three bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      count_q <= '0;
      result  <= '0;
    end else if (op_clear) begin
      acc_q   <= '0;
      count_q <= '0;
      result  <= '0;
    end else if (load) begin
      a_q     <= op_signed ? {{(AW-WIDTH){multiplicand[WIDTH-1]}}, multiplicand}
                           : {{(AW-WIDTH){1'b0}}, multiplicand};
      b_q     <= {b_ext, b_ext, multiplier, 1'b0};
      acc_q   <= '0;
      count_q <= '0;
      result  <= '0;
    end else if (state == CALC) begin
      acc_q   <= acc_next;
      a_q     <= a_q << 2;
      b_q     <= b_q >> 2;
      count_q <= count_q + CW'(1);
      if (count_q == LAST) begin
        result <= acc_next[2*WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_booth_mul_param.sv
// Directed and randomised checks of booth_mul_param at WIDTH=8 and WIDTH=64.
// Inputs are driven 1 time unit after a rising edge and sampled by the next one;
// outputs are observed 1 time unit after each rising edge.
module tb_booth_mul_param;

  logic         clk;
  logic         reset;

  logic         start8, clear8, signed8;
  logic [7:0]   mplier8, mcand8;
  logic         busy8, done8;
  logic [15:0]  result8;

  logic         start64, clear64, signed64;
  logic [63:0]  mplier64, mcand64;
  logic         busy64, done64;
  logic [127:0] result64;

  int checks;
  int errors;

  booth_mul_param #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .op_start(start8), .op_clear(clear8),
    .op_signed(signed8), .multiplier(mplier8), .multiplicand(mcand8),
    .op_busy(busy8), .op_done(done8), .result(result8)
  );

  booth_mul_param #(.WIDTH(64)) dut64 (
    .clk(clk), .reset(reset), .op_start(start64), .op_clear(clear64),
    .op_signed(signed64), .multiplier(mplier64), .multiplicand(mcand64),
    .op_busy(busy64), .op_done(done64), .result(result64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start an 8-bit op, wait (bounded) for done; lat counts edges from the drive edge
  task automatic do_op8(input logic sgn, input logic [7:0] a, input logic [7:0] b,
                        output logic [15:0] r, output int lat);
    signed8 = sgn; mcand8 = a; mplier8 = b; start8 = 1'b1;
    tick();
    lat = 1;
    start8 = 1'b0;
    while (!done8 && lat < 40) begin
      tick();
      lat++;
    end
    r = result8;
  endtask

  task automatic do_op64(input logic sgn, input logic [63:0] a, input logic [63:0] b,
                         output logic [127:0] r, output int lat);
    signed64 = sgn; mcand64 = a; mplier64 = b; start64 = 1'b1;
    tick();
    lat = 1;
    start64 = 1'b0;
    while (!done64 && lat < 80) begin
      tick();
      lat++;
    end
    r = result64;
  endtask

  task automatic clear_both();
    clear8 = 1'b1; clear64 = 1'b1;
    tick();
    clear8 = 1'b0; clear64 = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start8 = 1'b1; start64 = 1'b1;
    tick();
    checks++;
    if ({busy8, done8, result8} !== 18'h0) begin
      errors++;
      $display("[TB] FAIL reset8: got busy=%b done=%b result=%h, expected 0 0 0000", busy8, done8, result8);
    end
    checks++;
    if ({busy64, done64, result64} !== 130'h0) begin
      errors++;
      $display("[TB] FAIL reset64: got busy=%b done=%b result=%h, expected all zero", busy64, done64, result64);
    end
    reset = 1'b0; start8 = 1'b0; start64 = 1'b0;
  endtask

  // -128 * -128 signed: busy after edges 1..5, done and 0x4000 after edge 6
  task automatic test_timing();
    signed8 = 1'b1; mcand8 = 8'h80; mplier8 = 8'h80; start8 = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      start8 = 1'b0;
      checks++;
      if (busy8 !== 1'b1 || done8 !== 1'b0 || result8 !== 16'h0) begin
        errors++;
        $display("[TB] FAIL calc_edge%0d: got busy=%b done=%b result=%h, expected 1 0 0000", k, busy8, done8, result8);
      end
    end
    tick();
    checks++;
    if (busy8 !== 1'b0 || done8 !== 1'b1 || result8 !== 16'h4000) begin
      errors++;
      $display("[TB] FAIL done_edge6: got busy=%b done=%b result=%h, expected 0 1 4000", busy8, done8, result8);
    end
    mcand8 = 8'h11; mplier8 = 8'h22;
    tick(); tick();
    checks++;
    if (done8 !== 1'b1 || result8 !== 16'h4000) begin
      errors++;
      $display("[TB] FAIL done_hold: got done=%b result=%h, expected 1 4000", done8, result8);
    end
    clear8 = 1'b1;
    tick();
    clear8 = 1'b0;
    checks++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || result8 !== 16'h0) begin
      errors++;
      $display("[TB] FAIL clear_done: got busy=%b done=%b result=%h, expected 0 0 0000", busy8, done8, result8);
    end
  endtask

  // 0xFF * 0xFF in both modes
  task automatic test_modes();
    logic [15:0] r;
    int lat;
    do_op8(1'b0, 8'hFF, 8'hFF, r, lat);
    checks++;
    if (r !== 16'hFE01 || lat != 6) begin
      errors++;
      $display("[TB] FAIL unsigned_ff: got %h lat %0d, expected fe01 lat 6", r, lat);
    end
    clear_both();
    do_op8(1'b1, 8'hFF, 8'hFF, r, lat);
    checks++;
    if (r !== 16'h0001 || lat != 6) begin
      errors++;
      $display("[TB] FAIL signed_ff: got %h lat %0d, expected 0001 lat 6", r, lat);
    end
    clear_both();
  endtask

  // -128*1, then restart from DONE with 7*-3; a start pulse mid-CALC is ignored
  task automatic test_back_to_back();
    logic [15:0] r;
    int lat;
    do_op8(1'b1, 8'h80, 8'h01, r, lat);
    checks++;
    if (r !== 16'hFF80 || lat != 6) begin
      errors++;
      $display("[TB] FAIL signed_neg: got %h lat %0d, expected ff80 lat 6", r, lat);
    end
    mcand8 = 8'h07; mplier8 = 8'hFD; start8 = 1'b1;
    tick();
    checks++;
    if (busy8 !== 1'b1 || done8 !== 1'b0 || result8 !== 16'h0) begin
      errors++;
      $display("[TB] FAIL b2b_enter: got busy=%b done=%b result=%h, expected 1 0 0000", busy8, done8, result8);
    end
    start8 = 1'b0; mcand8 = 8'h55; mplier8 = 8'h33; signed8 = 1'b0;
    tick();
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    lat = 3;
    while (!done8 && lat < 40) begin
      tick();
      lat++;
    end
    checks++;
    if (result8 !== 16'hFFEB || lat != 6) begin
      errors++;
      $display("[TB] FAIL b2b_result: got %h lat %0d, expected ffeb lat 6", result8, lat);
    end
    clear_both();
  endtask

  // Abort mid-CALC (with start also high), reset mid-CALC, then a start right after reset
  task automatic test_abort_and_reset();
    logic [15:0] r;
    int lat;
    int done_seen;
    signed8 = 1'b0; mcand8 = 8'h0C; mplier8 = 8'h0D; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick(); tick();
    clear8 = 1'b1; start8 = 1'b1;
    tick();
    clear8 = 1'b0; start8 = 1'b0;
    checks++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || result8 !== 16'h0) begin
      errors++;
      $display("[TB] FAIL abort: got busy=%b done=%b result=%h, expected 0 0 0000", busy8, done8, result8);
    end
    done_seen = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (done8 !== 1'b0 || busy8 !== 1'b0) done_seen++;
    end
    checks++;
    if (done_seen != 0) begin
      errors++;
      $display("[TB] FAIL abort_quiet: got %0d active cycles, expected 0", done_seen);
    end
    mcand8 = 8'h0C; mplier8 = 8'h0D; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || result8 !== 16'h0) begin
      errors++;
      $display("[TB] FAIL reset_mid: got busy=%b done=%b result=%h, expected 0 0 0000", busy8, done8, result8);
    end
    do_op8(1'b0, 8'h03, 8'h05, r, lat);
    checks++;
    if (r !== 16'h000F || lat != 6) begin
      errors++;
      $display("[TB] FAIL start_after_reset: got %h lat %0d, expected 000f lat 6", r, lat);
    end
    clear_both();
  endtask

  // WIDTH=64: all-ones times one in both modes; done after edge 34, not 33
  task automatic test_wide();
    logic [127:0] r;
    int lat;
    do_op64(1'b1, {64{1'b1}}, 64'h1, r, lat);
    checks++;
    if (r !== {128{1'b1}} || lat != 34) begin
      errors++;
      $display("[TB] FAIL wide_signed: got %h lat %0d, expected all ones lat 34", r, lat);
    end
    clear_both();
    do_op64(1'b0, {64{1'b1}}, 64'h1, r, lat);
    checks++;
    if (r !== {64'h0, {64{1'b1}}} || lat != 34) begin
      errors++;
      $display("[TB] FAIL wide_unsigned: got %h lat %0d, expected 0000000000000000ffffffffffffffff lat 34", r, lat);
    end
    clear_both();
  endtask

  // Random operands against a plain extended-multiply reference, both modes
  task automatic test_random();
    logic [15:0]  r8, ea8, eb8, exp8;
    logic [127:0] r64, ea64, eb64, exp64;
    logic [7:0]   a8, b8;
    logic [63:0]  a64, b64;
    logic         sgn;
    int           lat;
    for (int i = 0; i < 16; i++) begin
      sgn = i[0];
      a8 = 8'($urandom); b8 = 8'($urandom);
      ea8 = sgn ? {{8{a8[7]}}, a8} : {8'h0, a8};
      eb8 = sgn ? {{8{b8[7]}}, b8} : {8'h0, b8};
      exp8 = ea8 * eb8;
      do_op8(sgn, a8, b8, r8, lat);
      checks++;
      if (r8 !== exp8 || lat != 6) begin
        errors++;
        $display("[TB] FAIL rand8 s=%b %h*%h: got %h lat %0d, expected %h lat 6", sgn, a8, b8, r8, lat, exp8);
      end
      clear_both();
    end
    for (int i = 0; i < 8; i++) begin
      sgn = i[0];
      a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom};
      ea64 = sgn ? {{64{a64[63]}}, a64} : {64'h0, a64};
      eb64 = sgn ? {{64{b64[63]}}, b64} : {64'h0, b64};
      exp64 = ea64 * eb64;
      do_op64(sgn, a64, b64, r64, lat);
      checks++;
      if (r64 !== exp64 || lat != 34) begin
        errors++;
        $display("[TB] FAIL rand64 s=%b: got %h lat %0d, expected %h lat 34", sgn, r64, lat, exp64);
      end
      clear_both();
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    reset = 1'b1;
    start8 = 1'b0; clear8 = 1'b0; signed8 = 1'b0; mplier8 = '0; mcand8 = '0;
    start64 = 1'b0; clear64 = 1'b0; signed64 = 1'b0; mplier64 = '0; mcand64 = '0;
    tick();
    test_reset();
    test_timing();
    test_modes();
    test_back_to_back();
    test_abort_and_reset();
    test_wide();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/booth_mul_param.md
BOOTH_MUL_PARAM -- requirements
Module: booth_mul_param

Interface
REQ-001 Parameter WIDTH, default 64, meaning operand width in bits; SHALL be even and >= 4.
REQ-002 Port clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-003 Port reset  input  1  reset, synchronous and active-high.
REQ-004 Port op_start  input  1  request to begin a multiplication.
REQ-005 Port op_clear  input  1  abort, or acknowledge and clear a finished result.
REQ-006 Port op_signed  input  1  mode select: 1 = both operands two's complement, 0 = both unsigned.
REQ-007 Port multiplier  input  WIDTH  operand B.
REQ-008 Port multiplicand  input  WIDTH  operand A.
REQ-009 Port op_busy  output  1  high while in CALC.
REQ-010 Port op_done  output  1  high while in DONE; result valid.
REQ-011 Port result  output  2*WIDTH  product; two's complement in signed mode.

Function
REQ-012 The block SHALL implement states IDLE, CALC and DONE as a registered FSM; op_busy and op_done SHALL be decoded from state only.
REQ-013 In IDLE, op_start=1 with op_clear=0 SHALL latch multiplier, multiplicand and op_signed, clear result and the iteration counter, and enter CALC next cycle.
REQ-014 Latched operands SHALL be used for the whole operation; input changes after the start cycle SHALL have no effect.
REQ-015 Arithmetic: multiplier extended by 2 bits (sign bit if signed, 0 if unsigned) plus an implicit 0 below bit 0, giving N = WIDTH/2 + 1 radix-4 Booth digits.
REQ-016 Each CALC cycle SHALL retire exactly one digit, in this order: add 0, +A, +2A, -2A, -A or 0 for triplets 000/111, 001/010, 011, 100, 101/110.
REQ-017 Partial products SHALL use an accumulator of at least 2*WIDTH+4 bits with A sign- or zero-extended per the latched mode; subtraction SHALL be one's complement plus carry-in.
REQ-018 Latency: with the start sampled at edge 0, CALC SHALL occupy cycles 1..N, DONE SHALL be entered at edge N+1, and op_done SHALL rise at edge N+1; latency is fixed and independent of operand values.
REQ-019 On entry to DONE, result SHALL equal the exact product truncated to 2*WIDTH bits, which is lossless for both modes.
REQ-020 In DONE, result and op_done SHALL hold until op_clear=1 or op_start=1.
REQ-021 DONE with op_clear=1 SHALL return to IDLE next cycle with result = 0 and op_done = 0.
REQ-022 DONE with op_start=1 and op_clear=0 SHALL latch new operands and enter CALC directly (back-to-back); result SHALL clear to 0 on that edge.
REQ-023 CALC with op_clear=1 SHALL abort to IDLE next cycle with result = 0; op_done SHALL never assert for an aborted operation.
REQ-024 op_start in CALC SHALL be ignored.
REQ-025 op_clear and op_start asserted together SHALL behave as op_clear alone in every state.
REQ-026 result SHALL read 0 in IDLE and during CALC; partial sums SHALL not be visible on the result port.

Reset
REQ-027 reset=1 at a rising edge SHALL force IDLE, result = 0, op_busy = 0, op_done = 0, counter = 0 and latched operands = 0, overriding all other inputs in any state, including mid-CALC.
REQ-028 The first op_start after reset deasserts SHALL be honoured in the cycle it is sampled.

Verification (WIDTH=8, N=5 unless noted)
REQ-029 Signed mode, A=0x80, B=0x80 (-128*-128), start pulse at edge 0 -> op_busy high for edges 1..5, op_done rises at edge 6, result = 0x4000.
REQ-030 Unsigned mode, A=0xFF, B=0xFF -> result = 0xFE01 at edge 6; the same operands in signed mode -> result = 0x0001.
REQ-031 Signed mode, A=0x80, B=0x01 -> result = 0xFF80; then op_start with A=0x07, B=0xFD held in DONE -> CALC the next cycle, op_done drops, result = 0xFFEB after 6 cycles.
REQ-032 op_clear at edge 3 during CALC -> IDLE at edge 4, result = 0, op_done never asserts; reset=1 at edge 2 of a new operation -> all outputs 0 at edge 3.
REQ-033 WIDTH=64: signed A = all ones, B = 0x1 -> result = 128 ones at edge 34; unsigned with the same operands -> result = 0x0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF.
REQ-034 Randomised operands against a reference product, both modes, WIDTH in {4, 8, 64} -> zero mismatches, and op_done exactly N+1 cycles after each accepted start.
